// File: rtl/weight_mem_loader_pkg.sv
// Shared codes for the weight-SRAM loader: memory select encodings, SRAM
// strobe levels, FSM states and a depth helper for the command range check.
package weight_mem_loader_pkg;

  typedef enum logic [1:0] {
    MEM_SEL_W    = 2'd0,
    MEM_SEL_U    = 2'd1,
    MEM_SEL_V    = 2'd2,
    MEM_SEL_RSVD = 2'd3
  } mem_sel_e;

  typedef enum logic [1:0] {
    LOADER_IDLE = 2'd0,
    LOADER_LOAD = 2'd1,
    LOADER_DONE = 2'd2
  } loader_state_e;

  localparam logic MEM_ACTIVE   = 1'b0;
  localparam logic MEM_INACTIVE = 1'b1;

  // Depth of the selected memory; the reserved code reports zero so any
  // command aimed at it fails the range check.
  function automatic logic [31:0] mem_depth(input mem_sel_e sel, input int w_aw,
                                            input int u_aw, input int v_aw);
    logic [31:0] depth;
    depth = 32'd0;
    case (sel)
      MEM_SEL_W: depth = 32'd1 << w_aw;
      MEM_SEL_U: depth = 32'd1 << u_aw;
      MEM_SEL_V: depth = 32'd1 << v_aw;
      default:   depth = 32'd0;
    endcase
    return depth;
  endfunction

endpackage

// File: rtl/weight_mem_loader_sram_wr_port.sv
// Registered write-side driver for one SRAM: one active-low strobe cycle per
// enable, addr/din parked at zero whenever the memory is not being written.
module sram_wr_port #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              cen_o,
  output logic              wen_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] din_o
);
  import weight_mem_loader_pkg::*;

  logic              cen_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  always_ff @(posedge clk) begin
    if (rst_i || !en_i) begin
      cen_q  <= MEM_INACTIVE;
      wen_q  <= MEM_INACTIVE;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      cen_q  <= MEM_ACTIVE;
      wen_q  <= MEM_ACTIVE;
      addr_q <= addr_i;
      din_q  <= din_i;
    end
  end

  assign cen_o  = cen_q;
  assign wen_o  = wen_q;
  assign addr_o = addr_q;
  assign din_o  = din_q;

endmodule

// File: rtl/weight_mem_loader.sv
// Streams command-sized bursts of weight words into the W/U/V SRAMs at
// consecutive addresses, backing off whenever inference owns the memories.
module weight_mem_loader #(
  parameter int DATA_W   = 16,
  parameter int W_ADDR_W = 12,
  parameter int U_ADDR_W = 10,
  parameter int V_ADDR_W = 10,
  parameter int CNT_W    = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mem_sel,
  input  logic [W_ADDR_W-1:0] cmd_base,
  input  logic [CNT_W-1:0]    cmd_len,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                comp_busy,
  output logic                w_mem_cen,
  output logic                w_mem_wen,
  output logic [W_ADDR_W-1:0] w_mem_addr,
  output logic [DATA_W-1:0]   w_mem_din,
  output logic                u_mem_cen,
  output logic                u_mem_wen,
  output logic [U_ADDR_W-1:0] u_mem_addr,
  output logic [DATA_W-1:0]   u_mem_din,
  output logic                v_mem_cen,
  output logic                v_mem_wen,
  output logic [V_ADDR_W-1:0] v_mem_addr,
  output logic [DATA_W-1:0]   v_mem_din,
  output logic                load_done,
  output logic                load_err
);
  import weight_mem_loader_pkg::*;

  loader_state_e       state_q;
  mem_sel_e            sel_q;
  logic [W_ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    idx_q;
  logic                done_q;
  logic                err_q;

  logic                beat;
  logic                last_beat;
  logic [W_ADDR_W-1:0] addr_d;
  logic [31:0]         cmd_end;
  logic [31:0]         cmd_depth;
  logic                cmd_bad;

  assign cmd_ready  = !rst && (state_q == LOADER_IDLE);
  assign data_ready = !rst && (state_q == LOADER_LOAD) && !comp_busy;
  assign beat       = data_valid && data_ready;
  assign last_beat  = (idx_q == len_q - CNT_W'(1));
  assign addr_d     = base_q + W_ADDR_W'(idx_q);

  // Range check in 32 bits so base+len cannot wrap before the compare.
  assign cmd_depth = mem_depth(mem_sel_e'(cmd_mem_sel), W_ADDR_W, U_ADDR_W, V_ADDR_W);
  assign cmd_end   = 32'(cmd_base) + 32'(cmd_len);
  assign cmd_bad   = (mem_sel_e'(cmd_mem_sel) == MEM_SEL_RSVD) || (cmd_end > cmd_depth);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOADER_IDLE;
      sel_q   <= MEM_SEL_W;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        LOADER_IDLE: begin
          if (cmd_valid) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              sel_q  <= mem_sel_e'(cmd_mem_sel);
              base_q <= cmd_base;
              len_q  <= cmd_len;
              idx_q  <= '0;
              if (cmd_len == '0) begin
                state_q <= LOADER_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= LOADER_LOAD;
              end
            end
          end
        end
        LOADER_LOAD: begin
          // done_q lands in the same cycle as the final write strobe
          if (beat) begin
            idx_q <= idx_q + CNT_W'(1);
            if (last_beat) begin
              state_q <= LOADER_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        LOADER_DONE: state_q <= LOADER_IDLE;
        default:     state_q <= LOADER_IDLE;
      endcase
    end
  end

  assign load_done = done_q;
  assign load_err  = err_q;

  sram_wr_port #(.ADDR_W(W_ADDR_W), .DATA_W(DATA_W)) u_w_port (
    .clk    (clk),
    .rst_i  (rst),
    .en_i   (beat && (sel_q == MEM_SEL_W)),
    .addr_i (addr_d),
    .din_i  (data_in),
    .cen_o  (w_mem_cen),
    .wen_o  (w_mem_wen),
    .addr_o (w_mem_addr),
    .din_o  (w_mem_din)
  );

  sram_wr_port #(.ADDR_W(U_ADDR_W), .DATA_W(DATA_W)) u_u_port (
    .clk    (clk),
    .rst_i  (rst),
    .en_i   (beat && (sel_q == MEM_SEL_U)),
    .addr_i (addr_d[U_ADDR_W-1:0]),
    .din_i  (data_in),
    .cen_o  (u_mem_cen),
    .wen_o  (u_mem_wen),
    .addr_o (u_mem_addr),
    .din_o  (u_mem_din)
  );

  sram_wr_port #(.ADDR_W(V_ADDR_W), .DATA_W(DATA_W)) u_v_port (
    .clk    (clk),
    .rst_i  (rst),
    .en_i   (beat && (sel_q == MEM_SEL_V)),
    .addr_i (addr_d[V_ADDR_W-1:0]),
    .din_i  (data_in),
    .cen_o  (v_mem_cen),
    .wen_o  (v_mem_wen),
    .addr_o (v_mem_addr),
    .din_o  (v_mem_din)
  );

endmodule

// File: tb/tb_weight_mem_loader.sv
// Scoreboard bench: the driver predicts each write/done/err event with its
// cycle from the loader's rules; a negedge monitor pops and compares them.
module tb_weight_mem_loader;

  localparam int K_NONE = 0;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mem_sel;
  logic [11:0] cmd_base;
  logic [12:0] cmd_len;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] data_in;
  logic        comp_busy;
  logic        w_mem_cen, w_mem_wen, u_mem_cen, u_mem_wen, v_mem_cen, v_mem_wen;
  logic [11:0] w_mem_addr;
  logic [9:0]  u_mem_addr, v_mem_addr;
  logic [15:0] w_mem_din, u_mem_din, v_mem_din;
  logic        load_done, load_err;

  weight_mem_loader dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mem_sel(cmd_mem_sel),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .comp_busy(comp_busy),
    .w_mem_cen(w_mem_cen), .w_mem_wen(w_mem_wen), .w_mem_addr(w_mem_addr), .w_mem_din(w_mem_din),
    .u_mem_cen(u_mem_cen), .u_mem_wen(u_mem_wen), .u_mem_addr(u_mem_addr), .u_mem_din(u_mem_din),
    .v_mem_cen(v_mem_cen), .v_mem_wen(v_mem_wen), .v_mem_addr(v_mem_addr), .v_mem_din(v_mem_din),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int sel;
    int addr;
    int data;
    int last;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  nvec = 0;
  int  nerr = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int sel, input int addr, input int data,
                      input int last, input int at);
    ev_t e;
    e.kind = kind; e.sel = sel; e.addr = addr; e.data = data; e.last = last; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every event the DUT shows must be the next predicted one, on its cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      int ns, ssel, okind;
      logic [31:0] oaddr, odin, owen;
      ev_t e;
      ns = 0; ssel = -1; oaddr = 0; odin = 0; owen = 1;
      if (v_mem_cen == 1'b0) begin ns++; ssel = 2; oaddr = 32'(v_mem_addr); odin = 32'(v_mem_din); owen = 32'(v_mem_wen); end
      if (u_mem_cen == 1'b0) begin ns++; ssel = 1; oaddr = 32'(u_mem_addr); odin = 32'(u_mem_din); owen = 32'(u_mem_wen); end
      if (w_mem_cen == 1'b0) begin ns++; ssel = 0; oaddr = 32'(w_mem_addr); odin = 32'(w_mem_din); owen = 32'(w_mem_wen); end
      if (w_mem_cen) chk("w_idle_outputs", 32'({w_mem_wen, w_mem_addr, w_mem_din}), 32'({1'b1, 28'd0}));
      if (u_mem_cen) chk("u_idle_outputs", 32'({u_mem_wen, u_mem_addr, u_mem_din}), 32'({1'b1, 26'd0}));
      if (v_mem_cen) chk("v_idle_outputs", 32'({v_mem_wen, v_mem_addr, v_mem_din}), 32'({1'b1, 26'd0}));

      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("event_missing_kind", 32'(K_NONE), 32'(e.kind));
      end

      okind = (ns > 0) ? K_WR : load_done ? K_DONE : load_err ? K_ERR : K_NONE;
      if (okind != K_NONE || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          chk("unexpected_event", 32'(okind), 32'(K_NONE));
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", 32'(okind), 32'(e.kind));
          if (e.kind == K_WR) begin
            chk("strobe_count", 32'(ns), 32'd1);
            chk("wr_mem_sel", 32'(ssel), 32'(e.sel));
            chk("wr_addr", oaddr, 32'(e.addr));
            chk("wr_data", odin, 32'(e.data));
            chk("wr_wen", owen, 32'd0);
            chk("load_done_with_write", 32'(load_done), 32'(e.last));
            chk("load_err_with_write", 32'(load_err), 32'd0);
            $display("cycle %0d: write mem=%0d addr=0x%0h data=0x%0h last=%0d",
                     cyc, ssel, oaddr, odin, e.last);
          end else if (e.kind == K_DONE) begin
            chk("load_err_with_done", 32'(load_err), 32'd0);
            $display("cycle %0d: load_done without writes", cyc);
          end else begin
            chk("load_done_with_err", 32'(load_done), 32'd0);
            $display("cycle %0d: load_err", cyc);
          end
        end
      end
    end
  end

  // Issue a command from IDLE and predict its immediate outcome.
  task automatic send_cmd(input int sel, input int base, input int len, output bit go);
    int depth, w;
    depth = (sel == 0) ? 4096 : 1024;
    cmd_valid = 1'b1; cmd_mem_sel = 2'(sel); cmd_base = 12'(base); cmd_len = 13'(len);
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 10) begin
      @(posedge clk); #1; @(negedge clk); w++;
    end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    go = 1'b0;
    if (sel == 3 || base + len > depth) push(K_ERR, 0, 0, 0, 0, cyc + 1);
    else if (len == 0)                  push(K_DONE, 0, 0, 0, 0, cyc + 1);
    else                                go = 1'b1;
    $display("cycle %0d: cmd sel=%0d base=0x%0h len=%0d", cyc, sel, base, len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Feed data beats; optional forced stall after beat stall_k, optional abort after abort_k beats.
  task automatic stream(input int sel, input int base, input int len, input int pct,
                        input int stall_k, input int stall_n, input int busy_pct, input int abort_k);
    int k, budget, stall_left;
    bit exp_ready;
    k = 0; budget = 0; stall_left = stall_n;
    while (k < len && k != abort_k) begin
      if (budget++ > 2000) begin
        chk("stream_timeout_beats", 32'(k), 32'(len));
        break;
      end
      data_valid = ($urandom_range(99) < pct);
      data_in    = 16'($urandom);
      if (k == stall_k && stall_left > 0) begin
        comp_busy = 1'b1;
        stall_left--;
      end else begin
        comp_busy = ($urandom_range(99) < busy_pct);
      end
      @(negedge clk);
      exp_ready = !comp_busy;
      chk("data_ready_load", 32'(data_ready), 32'(exp_ready));
      if (data_valid && exp_ready) begin
        push(K_WR, sel, base + k, int'(data_in), (k == len - 1) ? 1 : 0, cyc + 1);
        k++;
      end
      @(posedge clk); #1;
    end
    comp_busy = 1'b0;
    data_valid = 1'b0;
    if (abort_k < 0 && k == len) begin
      // DONE cycle: neither handshake may open, even with data offered
      data_valid = 1'b1;
      data_in    = 16'($urandom);
      @(negedge clk);
      chk("cmd_ready_done", 32'(cmd_ready), 32'd0);
      chk("data_ready_done", 32'(data_ready), 32'd0);
      @(posedge clk); #1;
      data_valid = 1'b0;
    end
  endtask

  task automatic run_load(input int sel, input int base, input int len, input int pct,
                          input int stall_k, input int stall_n, input int busy_pct);
    bit go;
    send_cmd(sel, base, len, go);
    if (go) stream(sel, base, len, pct, stall_k, stall_n, busy_pct, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit go;
    rst = 1'b1; cmd_valid = 1'b0; cmd_mem_sel = 2'd0; cmd_base = '0; cmd_len = '0;
    data_valid = 1'b0; data_in = '0; comp_busy = 1'b0;
    repeat (3) @(posedge clk);
    data_valid = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_data_ready", 32'(data_ready), 32'd0);
    chk("reset_cens", 32'({w_mem_cen, u_mem_cen, v_mem_cen}), 32'h7);
    chk("reset_pulses", 32'({load_done, load_err}), 32'd0);
    chk("reset_w_addr", 32'(w_mem_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; data_valid = 1'b0;
    mon_en = 1'b1;

    // 1: W burst, back-to-back
    run_load(0, 'h010, 4, 100, -1, 0, 0);
    // 2: U burst ending at the top of U, then one that would overrun it
    run_load(1, 'h3FE, 2, 100, -1, 0, 0);
    run_load(1, 'h3FF, 2, 100, -1, 0, 0);
    // 3: V burst with a 3-cycle inference stall after beat 2
    run_load(2, 'h120, 6, 100, 2, 3, 0);
    // 4: zero-length W command, reserved target
    run_load(0, 'h055, 0, 100, -1, 0, 0);
    run_load(3, 'h000, 3, 100, -1, 0, 0);
    // 5: reset after three beats of an eight-beat load
    send_cmd(0, 'h200, 8, go);
    stream(0, 'h200, 8, 100, -1, 0, 0, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_forces_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_forces_data_ready", 32'(data_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cens", 32'({w_mem_cen, u_mem_cen, v_mem_cen}), 32'h7);
    chk("post_rst_w_addr", 32'(w_mem_addr), 32'd0);
    chk("post_rst_done", 32'(load_done), 32'd0);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    run_load(1, 'h005, 3, 100, -1, 0, 0);
    // 6: W burst with randomly gapped data_valid
    run_load(0, 'hF00, 16, 50, -1, 0, 0);
    // W load ending exactly at the top of W
    run_load(0, 'hFFC, 4, 80, -1, 0, 10);

    // Random commands, mostly in range, with random stalls and gaps
    for (int n = 0; n < 14; n++) begin
      int sel, depth, len, base;
      sel   = $urandom_range(3);
      depth = (sel == 0) ? 4096 : 1024;
      len   = $urandom_range(20);
      if ($urandom_range(4) == 0) base = $urandom_range(depth - 1);
      else                        base = $urandom_range(depth - len);
      run_load(sel, base, len, 70, -1, 0, 15);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
